// File: rtl/key_evt_pkg.sv
// Shared types and helpers for the key event decoder: FSM state encoding,
// cycles-per-millisecond helper and the millisecond counter width.
package key_evt_pkg;

  localparam int MS_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LHELD,
    WAIT2,
    HOLD2
  } key_state_t;

  function automatic int ms_cycles(input int freq);
    return freq / 1000;
  endfunction

endpackage

// File: rtl/key_event_decoder_ms_tick_gen.sv
// Millisecond prescaler: tick is high during the terminal count cycle;
// clr restarts the count so timing is aligned to the moment of clearing.
module ms_tick_gen
  import key_evt_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CYC = ms_cycles(CLK_FREQ);
  localparam int W   = $clog2(CYC);

  logic [W-1:0] presc;

  assign tick = (presc == W'(CYC - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc <= '0;
    end else if (clr || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Classifies one debounced active-low key into short/long/repeat pulses and a
// held level. Define KEY_EVT_DCLICK_EN to add double-click recognition.
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int DCLICK_MS = 300
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_value,
  input  logic key_flag,
  output logic short_press,
  output logic long_press,
  output logic repeat_press,
  output logic dclick_press,
  output logic key_held
);

  localparam logic [MS_CNT_W-1:0] LONG_LAST = MS_CNT_W'(LONG_MS - 1);
  localparam logic [MS_CNT_W-1:0] REP_LAST  = MS_CNT_W'(REPEAT_MS - 1);

  key_state_t          state;
  logic                lvl;
  logic [MS_CNT_W-1:0] ms_cnt;
  logic                tick;
  logic                restart;
  logic                press_ev;
  logic                rel_ev;
  logic                long_hit;
  logic                rep_hit;

  // Strobes that merely repeat the latched level carry no new information.
  assign press_ev = key_flag & ~key_value & lvl;
  assign rel_ev   = key_flag & key_value & ~lvl;
  assign long_hit = tick && (ms_cnt == LONG_LAST);
  assign rep_hit  = tick && (ms_cnt == REP_LAST);

`ifdef KEY_EVT_DCLICK_EN
  localparam logic [MS_CNT_W-1:0] DCLK_LAST = MS_CNT_W'(DCLICK_MS - 1);
  logic dc_hit;
  assign dc_hit = tick && (ms_cnt == DCLK_LAST);
`endif

  ms_tick_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_ms_tick_gen (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr      (restart),
    .tick     (tick)
  );

  // Every state change restarts both the prescaler and the ms counter.
  always_comb begin
    restart = 1'b0;
    case (state)
      IDLE:    restart = press_ev;
      PRESSED: restart = rel_ev | long_hit;
      LHELD:   restart = rel_ev;
`ifdef KEY_EVT_DCLICK_EN
      WAIT2:   restart = press_ev | dc_hit;
      HOLD2:   restart = rel_ev;
`endif
      default: restart = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      lvl          <= 1'b1;
      ms_cnt       <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;
      key_held     <= 1'b0;
`ifdef KEY_EVT_DCLICK_EN
      dclick_press <= 1'b0;
`endif
    end else begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;
`ifdef KEY_EVT_DCLICK_EN
      dclick_press <= 1'b0;
`endif

      if (press_ev) begin
        lvl      <= 1'b0;
        key_held <= 1'b1;
      end else if (rel_ev) begin
        lvl      <= 1'b1;
        key_held <= 1'b0;
      end

      if (restart || (state == LHELD && rep_hit)) begin
        ms_cnt <= '0;
      end else if (tick) begin
        ms_cnt <= ms_cnt + 1'b1;
      end

      // Release is tested before any timer hit, so a coincident release wins.
      case (state)
        IDLE: begin
          if (press_ev) state <= PRESSED;
        end
        PRESSED: begin
          if (rel_ev) begin
`ifdef KEY_EVT_DCLICK_EN
            state <= WAIT2;
`else
            state       <= IDLE;
            short_press <= 1'b1;
`endif
          end else if (long_hit) begin
            long_press <= 1'b1;
            state      <= LHELD;
          end
        end
        LHELD: begin
          if (rel_ev) begin
            state <= IDLE;
          end else if (rep_hit) begin
            repeat_press <= 1'b1;
          end
        end
`ifdef KEY_EVT_DCLICK_EN
        WAIT2: begin
          if (press_ev) begin
            dclick_press <= 1'b1;
            state        <= HOLD2;
          end else if (dc_hit) begin
            short_press <= 1'b1;
            state       <= IDLE;
          end
        end
        HOLD2: begin
          if (rel_ev) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifndef KEY_EVT_DCLICK_EN
  assign dclick_press = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: expected pulses (kind, cycle) are
// queued when key strobes are driven and matched as the DUT emits them.
module tb_key_event_decoder;

  localparam int K_SHORT = 0;
  localparam int K_LONG  = 1;
  localparam int K_REP   = 2;
  localparam int K_DCL   = 3;
`ifdef KEY_EVT_DCLICK_EN
  localparam int SHORT_DLY = 30;
`else
  localparam int SHORT_DLY = 0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_value = 1'b1;
  logic key_flag = 1'b0;
  logic short_press, long_press, repeat_press, dclick_press, key_held;

  typedef struct {
    int kind;
    int at;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  key_event_decoder #(
    .CLK_FREQ (10_000),
    .LONG_MS  (5),
    .REPEAT_MS(2),
    .DCLICK_MS(3)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_value   (key_value),
    .key_flag    (key_flag),
    .short_press (short_press),
    .long_press  (long_press),
    .repeat_press(repeat_press),
    .dclick_press(dclick_press),
    .key_held    (key_held)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
    end else begin
      $display("ok   %s got=%0d cyc=%0d", tag, got, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Called 1ns after an edge; returns the edge number that sampled the strobe.
  task automatic strobe(input logic v, output int e);
    key_flag  = 1'b1;
    key_value = v;
    @(posedge sys_clk);
    #1;
    e        = cyc;
    key_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Press, hold for 'hold' edges, release; expectations follow the key timing rules.
  task automatic press_hold(input int hold);
    int p, r;
    strobe(1'b0, p);
    check("held_on", key_held, 1);
    r = p + hold;
    if (hold > 50) begin
      push(K_LONG, p + 50);
      for (int t = p + 70; t < r; t += 20) push(K_REP, t);
    end else begin
      push(K_SHORT, r + SHORT_DLY);
    end
    idle(hold - 1);
    strobe(1'b1, r);
    check("held_off", key_held, 0);
    idle(50);
  endtask

  always @(negedge sys_clk) begin : monitor
    int   n;
    int   k;
    exp_t e;
    n = int'(short_press) + int'(long_press) + int'(repeat_press) + int'(dclick_press);
    if (n > 1) check("pulse_exclusive", n, 1);
    if (n >= 1) begin
      k = short_press ? K_SHORT : long_press ? K_LONG : repeat_press ? K_REP : K_DCL;
      if (sb.size() == 0) begin
        check("unexpected_pulse_kind", k, -1);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", k, e.kind);
        check("pulse_cyc", cyc, e.at);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, r, e;
    idle(3);
    check("reset_outs", int'({short_press, long_press, repeat_press, dclick_press, key_held}), 0);
    sys_rst_n = 1'b1;
    idle(5);

    // Short press, long hold with repeats, release coinciding with the long tick.
    press_hold(20);
    press_hold(120);
    press_hold(50);

    // Redundant strobes are ignored.
    strobe(1'b1, e);
    check("idle_release_ignored", key_held, 0);
    idle(10);
    strobe(1'b0, p);
    push(K_SHORT, p + 30 + SHORT_DLY);
    idle(9);
    strobe(1'b0, e);
    idle(9);
    strobe(1'b0, e);
    check("repeat_press_ignored", key_held, 1);
    idle(9);
    strobe(1'b1, r);
    check("held_off_after_dup", key_held, 0);
    idle(50);

    // Press, release, press again 20 edges later.
    strobe(1'b0, p);
    idle(19);
`ifndef KEY_EVT_DCLICK_EN
    push(K_SHORT, p + 20);
`endif
    strobe(1'b1, r);
    idle(19);
    strobe(1'b0, p);
`ifdef KEY_EVT_DCLICK_EN
    push(K_DCL, p);
`endif
    check("held_second_press", key_held, 1);
    idle(19);
`ifndef KEY_EVT_DCLICK_EN
    push(K_SHORT, p + 20);
`endif
    strobe(1'b1, r);
    check("held_off_second", key_held, 0);
    idle(50);

    // Reset while in the long-held state.
    strobe(1'b0, p);
    push(K_LONG, p + 50);
    idle(60);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("midpress_reset_outs", int'({short_press, long_press, repeat_press, dclick_press, key_held}), 0);
    idle(2);
    sys_rst_n = 1'b1;
    idle(3);
    strobe(1'b1, e);
    check("release_after_reset", key_held, 0);
    idle(40);
    press_hold(20);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
Consumer end of the debounced-key interface: takes one key's debounced level and its one-cycle valid strobe, and classifies operator actions for the RTC/segment-LED setting logic.
- Emits one-cycle pulses for short press, long press and auto-repeat while held.
- Drives a held level.
- Key is active-low: 0 = pressed.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz; cycles per ms = CLK_FREQ/1000, must be ≥ 2.
LONG_MS, 1000, hold time in ms before long_press fires; range 1..65535.
REPEAT_MS, 200, auto-repeat period in ms after long_press; range 1..65535.
DCLICK_MS, 300, double-click window in ms; used only with the optional feature.

Ports:
sys_clk  in  1  system clock.
sys_rst_n  in  1  asynchronous active-low reset.
key_value  in  1  debounced key level, 0 = pressed.
key_flag  in  1  one-cycle strobe; key_value is valid while high.
short_press  out  1  one-cycle pulse, short press recognised.
long_press  out  1  one-cycle pulse, hold reached LONG_MS.
repeat_press  out  1  one-cycle pulse every REPEAT_MS after long_press while held.
dclick_press  out  1  one-cycle pulse, double click; tied 0 when the feature is out.
key_held  out  1  level, 1 while the key is logically pressed.

Behaviour:
- Reset sys_rst_n: asynchronous, active-low. Clock sys_clk. All logic is posedge sys_clk.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Internal level latch lvl = 1 (released).
  - Prescaler and ms counter 0.
- Edge qualification:
  - press_ev = key_flag & !key_value & lvl.
  - rel_ev = key_flag & key_value & !lvl.
  - A strobe that repeats the current level is ignored.
  - lvl updates on every qualified event.
- ms tick:
  - Prescaler counts 0..CLK_FREQ/1000-1; tick is asserted at terminal count.
  - Prescaler and ms counter clear on every state transition, so timing restarts at each entry.
- States:
  - IDLE
    - press_ev → PRESSED.
  - PRESSED
    - rel_ev → IDLE and short_press (WAIT2 with the feature).
    - ms counter reaches LONG_MS on a tick → long_press, go to LHELD.
  - LHELD
    - Every REPEAT_MS ticks → repeat_press, ms counter clears.
    - rel_ev → IDLE with no pulse.
- Output timing:
  - All pulses are registered and appear exactly 1 cycle after the causing key_flag or tick cycle.
  - Pulses are mutually exclusive per cycle.
- key_held:
  - Set 1 cycle after press_ev.
  - Cleared 1 cycle after rel_ev.
- Simultaneous events: rel_ev and a terminal tick in the same cycle → release wins. No long_press or repeat_press; short_press is emitted if in PRESSED.
- Width: ms counter is 16 bit unsigned. The prescaler width is $clog2(CLK_FREQ/1000).
- Reset mid-press: return to IDLE with lvl = 1. A key still physically down is seen only after the next key_flag with value 0.

Optional Feature:
Macro KEY_EVT_DCLICK_EN.
- Defined: adds states WAIT2 and HOLD2.
  - Release from PRESSED → WAIT2, no pulse yet.
  - WAIT2 with press_ev before DCLICK_MS ticks → dclick_press, go to HOLD2.
  - WAIT2 reaching DCLICK_MS → short_press, go to IDLE.
  - HOLD2 waits for rel_ev → IDLE with no pulse; no long press is recognised from HOLD2.
  - Short-press latency grows by DCLICK_MS.
- Not defined:
  - WAIT2 and HOLD2 are not built.
  - dclick_press is constant 0.
  - short_press fires on release.

Decomposition:
- Package key_evt_pkg holds:
  - the state enum (IDLE, PRESSED, LHELD, WAIT2, HOLD2);
  - an ms_cycles(freq) constant function;
  - the 16-bit ms counter width.
- One sub-module, ms_tick_gen: prescaler with a synchronous clear input and a tick output, parameter CLK_FREQ.

Test Plan:
All scenarios use CLK_FREQ=10_000 (10 cycles/ms), LONG_MS=5, REPEAT_MS=2, DCLICK_MS=3.
- Press strobe (value 0) → key_held=1 next cycle. Release strobe 20 cycles later → short_press high exactly 1 cycle after the release strobe; no long_press.
- Hold 120 cycles → long_press 51 cycles after the press strobe; repeat_press every 20 cycles afterwards. Release → no short_press, key_held=0.
- Repeated strobe with value 1 while idle, and value 0 twice while pressed → no state change, no pulses.
- Release strobe and the 50th-cycle tick coincide → short_press only; long_press stays 0.
- Assert sys_rst_n=0 during LHELD → all outputs 0 immediately. After reset, a release strobe produces nothing.
- With KEY_EVT_DCLICK_EN: press, release, then press again 20 cycles after the release → dclick_press 1 cycle after the second press, no short_press. Single click → short_press 31 cycles after the release.
